// File: rtl/keyboard_ctl.sv
// keyboard_ctl: PS/2 set-2 scan-code decoder producing held left/right/jump levels.
// Define KEYBOARD_JUMP_ONESHOT_EN to make jump a one-cycle pulse on a fresh make.
module keyboard_ctl #(
   parameter logic [7:0] LEFT_CODE   = 8'h6B,
   parameter logic [7:0] RIGHT_CODE  = 8'h74,
   parameter logic [7:0] JUMP_CODE   = 8'h29,
   parameter int         TIMEOUT_CYC = 100_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       left,
   output logic       right,
   output logic       jump
);
   typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BREAK, ST_EXT_BREAK} state_e;
   localparam logic [16:0] TO_LAST = 17'(TIMEOUT_CYC - 1);
   state_e      state_q, state_d;
   logic [16:0] cnt_q, cnt_d;
   logic        left_held_q, left_held_d, right_held_q, right_held_d;
   logic        jump_held_q, jump_held_d, last_dir_q, last_dir_d;
   logic        left_q, left_d, right_q, right_d, jump_q, jump_d;
   logic        timeout, is_e0, is_f0, ext, is_make, is_break, hit_l, hit_r, hit_j;

   assign is_e0   = rx_data == 8'hE0;
   assign is_f0   = rx_data == 8'hF0;
   // A byte arriving on the timeout cycle still counts as part of the sequence
   assign timeout = state_q != ST_IDLE && cnt_q == TO_LAST && !rx_valid;
   assign cnt_d   = (rx_valid || timeout || state_q == ST_IDLE) ? '0 : cnt_q + 17'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         left_held_q  <= 1'b0;
         right_held_q <= 1'b0;
         jump_held_q  <= 1'b0;
         last_dir_q   <= 1'b0;
         left_q       <= 1'b0;
         right_q      <= 1'b0;
         jump_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         left_held_q  <= left_held_d;
         right_held_q <= right_held_d;
         jump_held_q  <= jump_held_d;
         last_dir_q   <= last_dir_d;
         left_q       <= left_d;
         right_q      <= right_d;
         jump_q       <= jump_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (timeout)
         state_d = ST_IDLE;
      else if (rx_valid)
         case (state_q)
            ST_IDLE:  state_d = is_e0 ? ST_EXT : is_f0 ? ST_BREAK : ST_IDLE;
            ST_EXT:   state_d = is_e0 ? ST_EXT : is_f0 ? ST_EXT_BREAK : ST_IDLE;
            ST_BREAK: state_d = is_f0 ? ST_BREAK : ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
   end

   always_comb begin
      ext          = state_q == ST_EXT || state_q == ST_EXT_BREAK;
      is_make      = rx_valid && (state_q == ST_IDLE || state_q == ST_EXT) && !is_e0 && !is_f0;
      is_break     = rx_valid && ((state_q == ST_BREAK && !is_f0) || state_q == ST_EXT_BREAK);
      hit_l        = ext && rx_data == LEFT_CODE;
      hit_r        = ext && rx_data == RIGHT_CODE;
      hit_j        = !ext && rx_data == JUMP_CODE;
      left_held_d  = (is_make && hit_l) ? 1'b1 : (is_break && hit_l) ? 1'b0 : left_held_q;
      right_held_d = (is_make && hit_r) ? 1'b1 : (is_break && hit_r) ? 1'b0 : right_held_q;
      jump_held_d  = (is_make && hit_j) ? 1'b1 : (is_break && hit_j) ? 1'b0 : jump_held_q;
      last_dir_d   = (is_make && hit_r) ? 1'b1 : (is_make && hit_l) ? 1'b0 : last_dir_q;
      left_d       = left_held_d & (~right_held_d | ~last_dir_d);
      right_d      = right_held_d & (~left_held_d | last_dir_d);
`ifdef KEYBOARD_JUMP_ONESHOT_EN
      jump_d       = is_make && hit_j && !jump_held_q;
`else
      jump_d       = jump_held_d;
`endif
   end

   assign left  = left_q;
   assign right = right_q;
   assign jump  = jump_q;
endmodule

// File: tb/tb_keyboard_ctl.sv
// tb_keyboard_ctl: directed scan-code sequences against hand-computed key levels.
module tb_keyboard_ctl;
   localparam int T = 20;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       left, right, jump;
   int         total = 0;
   int         bad = 0;
   int         pulses = 0;

   keyboard_ctl #(.TIMEOUT_CYC(T)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .left(left), .right(right), .jump(jump)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (jump === 1'b1) pulses <= pulses + 1;

   task automatic check(input string tag, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %b exp %b", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send2(input logic [7:0] a, input logic [7:0] b);
      rx_data  = a;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_left", left, 1'b0);
      check("rst_right", right, 1'b0);
      check("rst_jump", jump, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      send(8'hE0);
      check("prefix_only_left", left, 1'b0);
      send(8'h6B);
      check("make_left", left, 1'b1);
      check("make_left_right", right, 1'b0);
      send(8'hE0); send(8'hF0); send(8'h6B);
      check("break_left", left, 1'b0);

      send(8'hE0); send(8'h6B);
      send(8'hE0); send(8'h74);
      check("last_right_left", left, 1'b0);
      check("last_right_right", right, 1'b1);
      send(8'hE0); send(8'h6B);
      check("typematic_left_left", left, 1'b1);
      check("typematic_left_right", right, 1'b0);
      send(8'hE0); send(8'hF0); send(8'h6B);
      check("rel_left_right", right, 1'b1);
      send(8'hE0); send(8'h6B);
      send(8'hE0); send(8'hF0); send(8'h74);
      check("rel_right_left", left, 1'b1);
      check("rel_right_right", right, 1'b0);
      send(8'hE0); send(8'hF0); send(8'h6B);
      check("all_rel_left", left, 1'b0);

      send(8'h6B);
      check("noext_left", left, 1'b0);
      send(8'hE0); send(8'h29);
      check("ext_jump", jump, 1'b0);

      send2(8'hE0, 8'h74);
      check("b2b_right", right, 1'b1);
      send2(8'hE0, 8'hF0); send(8'h74);
      check("b2b_break_right", right, 1'b0);
      send(8'hE0); send(8'hE0); send(8'h6B);
      check("e0_reentry_left", left, 1'b1);
      send(8'hF0); send(8'hE0);
      check("e0_in_break_left", left, 1'b1);
      send(8'hE0); send(8'hF0); send(8'h6B);
      check("after_e0_break_left", left, 1'b0);

`ifdef KEYBOARD_JUMP_ONESHOT_EN
      pulses = 0;
      send(8'h29); send(8'h29); send(8'h29);
      #1;
      check("oneshot_one_pulse", pulses == 1, 1'b1);
      check("oneshot_low", jump, 1'b0);
      send(8'hF0); send(8'h29); send(8'h29);
      #1;
      check("oneshot_second_pulse", pulses == 2, 1'b1);
      send(8'hF0); send(8'h29);
`else
      send(8'h29);
      check("make_jump", jump, 1'b1);
      send(8'h29);
      check("typematic_jump", jump, 1'b1);
      send(8'hF0); send(8'h29);
      check("break_jump", jump, 1'b0);
      send(8'h29);
      send(8'hF0); send(8'hF0); send(8'h29);
      check("f0_reentry_jump", jump, 1'b0);
`endif

      send(8'hE0);
      repeat (T) @(negedge clk);
      send(8'h6B);
      check("timeout_left", left, 1'b0);
      send(8'hE0);
      repeat (T - 2) @(negedge clk);
      send(8'h6B);
      check("no_timeout_left", left, 1'b1);

      send(8'hE0);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_left", left, 1'b0);
      rst_n = 1'b1;
      send(8'h6B);
      check("midrst_discard_left", left, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
